// File: rtl/pixel_array_ctrl.sv
// Frame sequencer for the pixel array: erase, expose, ramp conversion with a
// code counter driven onto the shared DATA bus, then per-pixel readout.
module pixel_array_ctrl #(
  parameter int ADDR_BITS     = 2,
  parameter int PIXEL_NUM     = 4,
  parameter int ERASE_CYCLES  = 5,
  parameter int EXPOSE_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  output logic                 ERASE,
  output logic                 EXPOSE,
  output logic                 RAMP_EN,
  output logic                 READ,
  output logic [ADDR_BITS-1:0] PIXELADDR,
  inout  wire  [7:0]           DATA,
  output logic [7:0]           pixel_data,
  output logic [ADDR_BITS-1:0] pixel_index,
  output logic                 pixel_valid,
  output logic                 frame_done
);

  localparam int CONV_CYCLES = 256;
  localparam int READ_CYCLES = 2 * PIXEL_NUM;
  localparam int PH_MAX_A    = (ERASE_CYCLES > EXPOSE_CYCLES) ? ERASE_CYCLES : EXPOSE_CYCLES;
  localparam int PH_MAX_B    = (CONV_CYCLES > READ_CYCLES) ? CONV_CYCLES : READ_CYCLES;
  localparam int PH_MAX      = (PH_MAX_A > PH_MAX_B) ? PH_MAX_A : PH_MAX_B;
  localparam int CNT_W       = $clog2(PH_MAX);

  localparam logic [CNT_W-1:0] ERASE_LAST  = CNT_W'(ERASE_CYCLES - 1);
  localparam logic [CNT_W-1:0] EXPOSE_LAST = CNT_W'(EXPOSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CONV_LAST   = CNT_W'(CONV_CYCLES - 1);
  localparam logic [CNT_W-1:0] READ_LAST   = CNT_W'(READ_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ERASE   = 3'd1,
    S_EXPOSE  = 3'd2,
    S_CONVERT = 3'd3,
    S_READ    = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic                   erase_q, erase_d;
  logic                   expose_q, expose_d;
  logic                   ramp_q, ramp_d;
  logic                   read_q, read_d;
  logic                   drive_q, drive_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [7:0]             pdata_q, pdata_d;
  logic [ADDR_BITS-1:0]   pidx_q, pidx_d;
  logic                   valid_q, valid_d;
  logic                   done_q, done_d;
  logic                   capture_s;

  // Next-state and phase counter; the counter restarts at every state change.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_ERASE;
        else        state_d = S_IDLE;
      end
      S_ERASE: begin
        if (cnt_q == ERASE_LAST) state_d = S_EXPOSE;
        else                     state_d = S_ERASE;
      end
      S_EXPOSE: begin
        if (cnt_q == EXPOSE_LAST) state_d = S_CONVERT;
        else                      state_d = S_EXPOSE;
      end
      S_CONVERT: begin
        if (cnt_q == CONV_LAST) state_d = S_READ;
        else                    state_d = S_CONVERT;
      end
      S_READ: begin
        if (cnt_q == READ_LAST) begin
          if (enable) state_d = S_ERASE;
          else        state_d = S_IDLE;
        end else begin
          state_d = S_READ;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if ((state_d != state_q) || (state_d == S_IDLE)) begin
      cnt_d = {CNT_W{1'b0}};
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State and phase counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output next values; controls follow the state being entered, so they
  // switch on the same edge as the state itself.
  always_comb begin
    erase_d   = (state_d == S_ERASE);
    expose_d  = (state_d == S_EXPOSE);
    ramp_d    = (state_d == S_CONVERT);
    read_d    = (state_d == S_READ);
    drive_d   = (state_d == S_CONVERT);
    capture_s = (state_q == S_READ) && cnt_q[0];
    valid_d   = capture_s;
    done_d    = (state_q == S_READ) && (cnt_q == READ_LAST);

    if (state_d == S_READ) begin
      addr_d = ADDR_BITS'(cnt_d >> 1);
    end else begin
      addr_d = {ADDR_BITS{1'b0}};
    end

    // Odd read cycles: the pixel has had a full cycle to settle on DATA.
    if (capture_s) begin
      pdata_d = DATA;
      pidx_d  = addr_q;
    end else begin
      pdata_d = pdata_q;
      pidx_d  = pidx_q;
    end
  end

  // Registered control and readout outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      erase_q  <= 1'b0;
      expose_q <= 1'b0;
      ramp_q   <= 1'b0;
      read_q   <= 1'b0;
      drive_q  <= 1'b0;
      addr_q   <= {ADDR_BITS{1'b0}};
      pdata_q  <= 8'h00;
      pidx_q   <= {ADDR_BITS{1'b0}};
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      erase_q  <= erase_d;
      expose_q <= expose_d;
      ramp_q   <= ramp_d;
      read_q   <= read_d;
      drive_q  <= drive_d;
      addr_q   <= addr_d;
      pdata_q  <= pdata_d;
      pidx_q   <= pidx_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
    end
  end

  // During CONVERT the phase counter doubles as the ramp code (0..255).
  assign DATA        = drive_q ? cnt_q[7:0] : 8'hzz;

  assign ERASE       = erase_q;
  assign EXPOSE      = expose_q;
  assign RAMP_EN     = ramp_q;
  assign READ        = read_q;
  assign PIXELADDR   = addr_q;
  assign pixel_data  = pdata_q;
  assign pixel_index = pidx_q;
  assign pixel_valid = valid_q;
  assign frame_done  = done_q;

endmodule

// File: tb/tb_pixel_array_ctrl.sv
// Directed bench: default instance A and a short-phase instance B, each with a
// pixel model on DATA and weak pull-ups so an undriven bus reads 0xFF.
module tb_pixel_array_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int       first;
    int       last;
    logic [3:0] ctrl;   // {ERASE, EXPOSE, RAMP_EN, READ}
  } seg_t;

  seg_t tab_a [4];
  seg_t tab_b [4];

  int checks = 0;
  int errors = 0;

  logic reset_a, enable_a, reset_b, enable_b;

  logic       erase_a, expose_a, ramp_a, read_a, valid_a, done_a;
  logic [1:0] addr_a, idx_a;
  logic [7:0] pd_a, drv_a;
  wire  [7:0] data_a;

  logic       erase_b, expose_b, ramp_b, read_b, valid_b, done_b;
  logic [1:0] addr_b, idx_b;
  logic [7:0] pd_b, drv_b;
  wire  [7:0] data_b;

  function automatic logic [7:0] pix_val(input int sel, input logic [1:0] a);
    logic [7:0] v;
    v = 8'h00;
    if (sel == 0) begin
      case (a)
        2'd0: v = 8'h10;
        2'd1: v = 8'h20;
        2'd2: v = 8'h30;
        default: v = 8'h40;
      endcase
    end else begin
      case (a)
        2'd0: v = 8'h5A;
        2'd1: v = 8'hA5;
        2'd2: v = 8'hC3;
        default: v = 8'h00;
      endcase
    end
    return v;
  endfunction

  always_comb drv_a = pix_val(0, addr_a);
  always_comb drv_b = pix_val(1, addr_b);
  assign data_a = read_a ? drv_a : 8'hzz;
  assign data_b = read_b ? drv_b : 8'hzz;

  for (genvar i = 0; i < 8; i++) begin : g_pull
    pullup pu_a (data_a[i]);
    pullup pu_b (data_b[i]);
  end

  pixel_array_ctrl u_dut_a (
    .clk(clk), .reset(reset_a), .enable(enable_a),
    .ERASE(erase_a), .EXPOSE(expose_a), .RAMP_EN(ramp_a), .READ(read_a),
    .PIXELADDR(addr_a), .DATA(data_a),
    .pixel_data(pd_a), .pixel_index(idx_a),
    .pixel_valid(valid_a), .frame_done(done_a)
  );

  pixel_array_ctrl #(
    .ADDR_BITS(2), .PIXEL_NUM(3), .ERASE_CYCLES(1), .EXPOSE_CYCLES(1)
  ) u_dut_b (
    .clk(clk), .reset(reset_b), .enable(enable_b),
    .ERASE(erase_b), .EXPOSE(expose_b), .RAMP_EN(ramp_b), .READ(read_b),
    .PIXELADDR(addr_b), .DATA(data_b),
    .pixel_data(pd_b), .pixel_index(idx_b),
    .pixel_valid(valid_b), .frame_done(done_b)
  );

  task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Checks every output of one instance against its idle/reset values.
  task automatic chk_idle(input int sel, input int cyc);
    if (sel == 0) begin
      chk("idle_ctrl", cyc, {28'd0, erase_a, expose_a, ramp_a, read_a}, 32'd0);
      chk("idle_addr", cyc, {30'd0, addr_a}, 32'd0);
      chk("idle_valid", cyc, {31'd0, valid_a}, 32'd0);
      chk("idle_done", cyc, {31'd0, done_a}, 32'd0);
      chk("idle_data_hiz", cyc, {24'd0, data_a}, 32'hFF);
    end else begin
      chk("idle_ctrl_b", cyc, {28'd0, erase_b, expose_b, ramp_b, read_b}, 32'd0);
      chk("idle_addr_b", cyc, {30'd0, addr_b}, 32'd0);
      chk("idle_valid_b", cyc, {31'd0, valid_b}, 32'd0);
      chk("idle_done_b", cyc, {31'd0, done_b}, 32'd0);
      chk("idle_data_hiz_b", cyc, {24'd0, data_b}, 32'hFF);
    end
  endtask

  // Called at the negedge of cycle 0 with enable already high. Runs ncyc
  // cycles; nfr frames are expected before IDLE; enable drops after drop_k.
  task automatic run_frames(input int sel, input int nfr, input int drop_k, input int ncyc);
    seg_t       seg [4];
    int         flen, q, qp, frp, fr, c;
    logic [3:0] e_ctrl, a_ctrl;
    logic [1:0] e_addr, e_idx, a_addr, a_idx;
    logic [7:0] e_data, a_data, a_pd;
    logic       e_v, e_d, a_v, a_d;
    for (int s = 0; s < 4; s++) seg[s] = (sel == 0) ? tab_a[s] : tab_b[s];
    flen = seg[3].last;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      q  = ((k - 1) % flen) + 1;
      fr = (k - 1) / flen;
      e_ctrl = 4'd0; e_addr = 2'd0; e_data = 8'hFF;
      e_v = 1'b0; e_d = 1'b0; e_idx = 2'd0;
      if (fr < nfr) begin
        for (int s = 0; s < 4; s++)
          if (q >= seg[s].first && q <= seg[s].last) e_ctrl = seg[s].ctrl;
      end
      if (e_ctrl == 4'b0010) e_data = 8'(q - seg[2].first);
      if (e_ctrl == 4'b0001) begin
        c      = q - seg[3].first;
        e_addr = 2'(c / 2);
        e_data = pix_val(sel, e_addr);
      end
      if (k > 1) begin
        qp  = ((k - 2) % flen) + 1;
        frp = (k - 2) / flen;
        if (frp < nfr && qp >= seg[3].first && ((qp - seg[3].first) % 2) == 1) begin
          e_v   = 1'b1;
          e_idx = 2'((qp - seg[3].first) / 2);
          e_d   = (qp == flen);
        end
      end
      if (sel == 0) begin
        a_ctrl = {erase_a, expose_a, ramp_a, read_a}; a_addr = addr_a; a_data = data_a;
        a_v = valid_a; a_d = done_a; a_idx = idx_a; a_pd = pd_a;
      end else begin
        a_ctrl = {erase_b, expose_b, ramp_b, read_b}; a_addr = addr_b; a_data = data_b;
        a_v = valid_b; a_d = done_b; a_idx = idx_b; a_pd = pd_b;
      end
      chk("ctrl", k, {28'd0, a_ctrl}, {28'd0, e_ctrl});
      chk("pixeladdr", k, {30'd0, a_addr}, {30'd0, e_addr});
      chk("data", k, {24'd0, a_data}, {24'd0, e_data});
      chk("pixel_valid", k, {31'd0, a_v}, {31'd0, e_v});
      chk("frame_done", k, {31'd0, a_d}, {31'd0, e_d});
      if (e_v) begin
        chk("pixel_index", k, {30'd0, a_idx}, {30'd0, e_idx});
        chk("pixel_data", k, {24'd0, a_pd}, {24'd0, pix_val(sel, e_idx)});
      end
      if (k == drop_k) begin
        if (sel == 0) enable_a = 1'b0;
        else          enable_b = 1'b0;
      end
    end
  endtask

  initial begin
    tab_a[0] = '{first: 1,   last: 5,   ctrl: 4'b1000};
    tab_a[1] = '{first: 6,   last: 260, ctrl: 4'b0100};
    tab_a[2] = '{first: 261, last: 516, ctrl: 4'b0010};
    tab_a[3] = '{first: 517, last: 524, ctrl: 4'b0001};
    tab_b[0] = '{first: 1,   last: 1,   ctrl: 4'b1000};
    tab_b[1] = '{first: 2,   last: 2,   ctrl: 4'b0100};
    tab_b[2] = '{first: 3,   last: 258, ctrl: 4'b0010};
    tab_b[3] = '{first: 259, last: 264, ctrl: 4'b0001};

    reset_a = 1'b1; enable_a = 1'b0;
    reset_b = 1'b1; enable_b = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle(0, 0);
    chk("reset_pixel_data", 0, {24'd0, pd_a}, 32'd0);
    chk("reset_pixel_index", 0, {30'd0, idx_a}, 32'd0);

    // Three back-to-back frames, enable dropped during the third EXPOSE.
    reset_a = 1'b0; enable_a = 1'b1;
    run_frames(0, 3, 1058, 1580);
    chk_idle(0, 1580);

    // Reset pulse at code 100 of CONVERT aborts the frame.
    enable_a = 1'b1;
    run_frames(0, 1, 0, 361);
    reset_a = 1'b1;
    @(negedge clk);
    chk_idle(0, 362);
    chk("abort_ramp", 362, {31'd0, ramp_a}, 32'd0);
    reset_a = 1'b0;
    run_frames(0, 1, 10, 530);

    // Minimal phase lengths with three pixels.
    chk_idle(1, 0);
    chk("reset_pixel_data_b", 0, {24'd0, pd_b}, 32'd0);
    reset_b = 1'b0; enable_b = 1'b1;
    run_frames(1, 1, 2, 270);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
